// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for the 8-bit CPU datapath.
// Owns pc and ir, and decodes the datapath strobes from its state register.
module cpu_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] instr_in,
  input  logic [1:0]  flags,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic        enbuf,
  output logic        regfile_write,
  output logic        mem_write,
  output logic        mem_mux_sel,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WB,
    S_MEMW,
    S_MEMR,
    S_MEMB,
    S_BR,
    S_HALT
  } state_t;

  state_t      state, state_next;
  logic [7:0]  pc_next;
  logic        ir_load;
  logic        br_taken;

  function automatic state_t decode(input logic [15:0] w);
    case (w[15:12]) inside
      [4'h1:4'h5], [4'h8:4'hF]: decode = S_EXEC;
      4'h6:                     decode = S_MEMW;
      4'h7:                     decode = S_MEMR;
      default:                  decode = (w == 16'h0000) ? S_HALT : S_BR;
    endcase
  endfunction

  always_comb begin
    case (ir[3:0])
      4'b1000: br_taken = 1'b1;
      4'b0100: br_taken = flags[0];
      4'b0101: br_taken = ~flags[0];
      4'b0110: br_taken = flags[1];
      4'b0111: br_taken = ~flags[1];
      default: br_taken = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ir_load       = 1'b0;
    enbuf         = 1'b0;
    regfile_write = 1'b0;
    mem_write     = 1'b0;
    mem_mux_sel   = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state)
      S_FETCH: begin
        if (run) begin
          ir_load    = 1'b1;
          state_next = decode(instr_in);
        end
      end
      S_EXEC: begin
        enbuf      = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        // Loads keep RAM data selected through the write cycle.
        enbuf         = 1'b1;
        regfile_write = 1'b1;
        mem_mux_sel   = (ir[15:12] == 4'h7);
        retire        = 1'b1;
        pc_next       = pc + 8'd1;
        state_next    = S_FETCH;
      end
      S_MEMW: begin
        mem_write  = 1'b1;
        retire     = 1'b1;
        pc_next    = pc + 8'd1;
        state_next = S_FETCH;
      end
      S_MEMR: begin
        mem_mux_sel = 1'b1;
        state_next  = S_MEMB;
      end
      S_MEMB: begin
        mem_mux_sel = 1'b1;
        enbuf       = 1'b1;
        state_next  = S_WB;
      end
      S_BR: begin
        retire     = 1'b1;
        pc_next    = br_taken ? ir[11:4] : pc + 8'd1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= instr_in;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: vector table plus a per-cycle strobe scoreboard.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] instr_in;
  logic [1:0]  flags;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        enbuf, regfile_write, mem_write, mem_mux_sel, retire, halted;

  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_in(instr_in), .flags(flags),
    .pc(pc), .ir(ir), .enbuf(enbuf), .regfile_write(regfile_write),
    .mem_write(mem_write), .mem_mux_sel(mem_mux_sel), .retire(retire),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // {enbuf, regfile_write, mem_write, mem_mux_sel, retire, halted}
  logic [5:0] obs;
  assign obs = {enbuf, regfile_write, mem_write, mem_mux_sel, retire, halted};

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  flags;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t       vecs [12];
  logic [5:0] sb_q [$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0]  mpc;
  logic [15:0] mir;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle strobe trace after the fetch edge.
  task automatic push_trace(input logic [15:0] w);
    case (w[15:12])
      4'h6: sb_q.push_back(6'b001010);
      4'h7: begin
        sb_q.push_back(6'b000100);
        sb_q.push_back(6'b100100);
        sb_q.push_back(6'b110110);
      end
      4'h0: sb_q.push_back(6'b000010);
      default: begin
        sb_q.push_back(6'b100000);
        sb_q.push_back(6'b110010);
      end
    endcase
  endtask

  function automatic bit br_rule(input logic [3:0] c, input logic [1:0] f);
    return (c == 4'b1000) || (c == 4'b0100 && f[0]) || (c == 4'b0101 && !f[0]) ||
           (c == 4'b0110 && f[1]) || (c == 4'b0111 && !f[1]);
  endfunction

  // Entered and left at a falling edge with the controller in FETCH.
  task automatic run_instr(input logic [15:0] w, input logic [1:0] f,
                           input logic [7:0] exp_pc, input bit drop_run);
    logic [5:0] exp;
    instr_in = w;
    flags    = f;
    run      = 1'b1;
    push_trace(w);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      if (drop_run) run = 1'b0;
      exp = sb_q.pop_front();
      check("strobes", {10'd0, obs}, {10'd0, exp});
    end
    @(negedge clk);
    check("pc", {8'd0, pc}, {8'd0, exp_pc});
    check("ir", ir, w);
    check("fetch_idle", {10'd0, obs}, 16'd0);
    mpc = exp_pc;
    mir = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h8005, 2'b00, 8'h01};
    vecs[1]  = '{16'h0048, 2'b00, 8'h04};
    vecs[2]  = '{16'h62A0, 2'b00, 8'h05};
    vecs[3]  = '{16'h72A1, 2'b00, 8'h06};
    vecs[4]  = '{16'h1234, 2'b00, 8'h07};
    vecs[5]  = '{16'h5FFF, 2'b11, 8'h08};
    vecs[6]  = '{16'h0401, 2'b11, 8'h09};
    vecs[7]  = '{16'h0F04, 2'b01, 8'hF0};
    vecs[8]  = '{16'h0F05, 2'b01, 8'hF1};
    vecs[9]  = '{16'h0FF8, 2'b00, 8'hFF};
    vecs[10] = '{16'hA123, 2'b00, 8'h00};
    vecs[11] = '{16'h0307, 2'b10, 8'h01};

    rst_n = 1'b0; run = 1'b0; instr_in = 16'h0000; flags = 2'b00;
    #1;
    check("reset_pc", {8'd0, pc}, 16'h0000);
    check("reset_ir", ir, 16'h0000);
    check("reset_strobes", {10'd0, obs}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 8'h00; mir = 16'h0000;

    for (int i = 0; i < 12; i++)
      run_instr(vecs[i].instr, vecs[i].flags, vecs[i].exp_pc, 1'b0);

    // Branch matrix: park at 0x20, then branch toward 0x40.
    begin
      logic [3:0] conds [5];
      logic [3:0] c;
      logic [1:0] f;
      conds[0] = 4'b1000; conds[1] = 4'b0100; conds[2] = 4'b0101;
      conds[3] = 4'b0110; conds[4] = 4'b0111;
      for (int ci = 0; ci < 5; ci++) begin
        for (int fi = 0; fi < 4; fi++) begin
          c = conds[ci];
          f = fi[1:0];
          run_instr(16'h0208, 2'b00, 8'h20, 1'b0);
          run_instr({4'h0, 8'h40, c}, f, br_rule(c, f) ? 8'h40 : 8'h21, 1'b0);
        end
      end
    end

    // Halt: absorbing, pc frozen, no strobes whatever the inputs do.
    instr_in = 16'h0000; run = 1'b1;
    @(negedge clk);
    check("halt_enter", {10'd0, obs}, 16'h0001);
    check("halt_pc", {8'd0, pc}, {8'd0, mpc});
    for (int k = 0; k < 20; k++) begin
      instr_in = 16'($urandom);
      flags    = 2'($urandom);
      run      = 1'($urandom);
      @(negedge clk);
      check("halt_hold", {pc, 2'b00, obs}, {mpc, 2'b00, 6'b000001});
    end
    rst_n = 1'b0;
    #1;
    check("halt_reset_pc", {8'd0, pc}, 16'h0000);
    check("halt_reset_strobes", {10'd0, obs}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; mpc = 8'h00; mir = 16'h0000;

    // Stall in FETCH with run low.
    run = 1'b0; instr_in = 16'h8005;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_pc", {8'd0, pc}, {8'd0, mpc});
      check("stall_ir", ir, mir);
      check("stall_strobes", {10'd0, obs}, 16'd0);
    end

    // run dropped during EXEC: instruction completes, then stalls.
    run_instr(16'h8005, 2'b00, 8'h01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drop_stall", {pc, 2'b00, obs}, {mpc, 8'd0});
      check("drop_stall_ir", ir, mir);
    end

    // Asynchronous reset in MEMB drops strobes immediately.
    instr_in = 16'h72A1; run = 1'b1;
    @(negedge clk);
    check("abort_memr", {10'd0, obs}, 16'h0004);
    @(negedge clk);
    check("abort_memb", {10'd0, obs}, 16'h0024);
    #2 rst_n = 1'b0;
    #1;
    check("abort_strobes", {10'd0, obs}, 16'd0);
    check("abort_pc", {8'd0, pc}, 16'h0000);
    check("abort_ir", ir, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; mpc = 8'h00; mir = 16'h0000;
    run_instr(16'h8005, 2'b00, 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control sequencer for the 8-bit CPU datapath: ALU8, REGFILE, BUF8, the imm/mem muxes, MEM16 instruction memory and RAM. It owns the program counter and the instruction register. It fetches one 16-bit instruction at a time, decodes the opcode, and drives the datapath strobes (`enbuf`, `regfile_write`, `mem_write`, `mem_mux_sel`) through a clocked state machine. It sits between MEM16 (address out, instruction in) and the datapath control inputs.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  when 0, FSM holds in FETCH and does not latch a new instruction (stall).
- `instr_in`  in  16  instruction word from MEM16 at address `pc` (combinational read).
- `flags`  in  2  stored flags from REGFILE; [0] and [1] as produced by ALU8.
- `pc`  out  8  program counter, drives MEM16 address.
- `ir`  out  16  latched instruction; drives opcode/field decode to the datapath.
- `enbuf`  out  1  enables BUF8 onto the regfile data bus.
- `regfile_write`  out  1  regfile write strobe (data and flags).
- `mem_write`  out  1  RAM write strobe.
- `mem_mux_sel`  out  1  selects RAM output (1) or ALU result (0) into the buffer.
- `retire`  out  1  one-cycle pulse on the last cycle of each completed instruction.
- `halted`  out  1  high while in HALT.

## Operation
- Decode uses `ir[15:12]` as the opcode.
  - 1xxx: R-type ALU.
  - 0001–0101: C-type ALU.
  - 0110: RTM (store).
  - 0111: MTR (load).
  - 0000: branch or halt.
- The branch target is `ir[11:4]` and the branch condition is `ir[3:0]`.
  - 1000: always taken.
  - 0100: taken if `flags[0]`=1.
  - 0101: taken if `flags[0]`=0.
  - 0110: taken if `flags[1]`=1.
  - 0111: taken if `flags[1]`=0.
  - Any other code: not taken, treated as a no-op.
- An instruction word of 16'h0000 is HALT.
- States: FETCH, EXEC, WB, MEMW, MEMR, MEMB, BR, HALT.
- FETCH:
  - If `run`=1: `ir` <= `instr_in`. The next state is decoded from `instr_in`.
    - ALU → EXEC.
    - RTM → MEMW.
    - MTR → MEMR.
    - 16'h0000 → HALT.
    - Other 0000 → BR.
  - If `run`=0: stay in FETCH; `ir` and `pc` unchanged.
- ALU path: EXEC (`enbuf`=1) → WB (`enbuf`=1, `regfile_write`=1, `pc`<=`pc`+1, `retire`=1) → FETCH.
- Store path: MEMW (`mem_write`=1, `pc`<=`pc`+1, `retire`=1) → FETCH.
- Load path: MEMR (`mem_mux_sel`=1) → MEMB (`mem_mux_sel`=1, `enbuf`=1) → WB with `mem_mux_sel` held at 1 → FETCH.
- BR: `flags` are sampled this cycle. If taken, `pc`<=`ir[11:4]`; otherwise `pc`<=`pc`+1. `retire`=1 → FETCH.
- HALT: absorbing. All strobes are 0 and `pc` is frozen. Only `rst_n` exits.
- Strobes are Moore outputs decoded from the state register (and `ir` for `mem_mux_sel` in WB). They are never asserted in FETCH or HALT.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
- `run` is sampled only in FETCH. Deasserting it mid-instruction does not abort the instruction; the controller stalls at the next FETCH.

## Timing
- On reset assertion (asynchronous):
  - State = FETCH.
  - `pc` = `RESET_PC`, `ir` = 16'h0000.
  - `enbuf`, `regfile_write`, `mem_write`, `mem_mux_sel`, `retire`, `halted` all = 0.
- Reset deassertion is synchronous to `clk`. The first fetch occurs on the first rising edge with `rst_n`=1 and `run`=1.
- Reset mid-instruction aborts immediately. Strobes drop asynchronously and no partial write is retried.
- Latency in cycles, including FETCH: ALU 3, store 2, load 4, branch 2. HALT is reached 1 cycle after fetch.
- `regfile_write` is asserted only in WB. `enbuf` has already been high for at least 1 full cycle by then, so the buffered data is stable before the write.
- `mem_write` is high for exactly 1 cycle per store.
- In MTR, `mem_mux_sel` is high for 3 consecutive cycles covering MEMR, MEMB and WB.
- `retire` is high for exactly 1 cycle per instruction and never during HALT.
- Flags written in a WB are visible to a BR that immediately follows, via the 1-cycle FETCH gap.

## Test plan
- Reset, `run`=1, MEM16[0]=16'h8_0_05 (R-type): `ir`=16'h8005 after edge 1; `enbuf`=1 cycles 2–3; `regfile_write`=1 cycle 3 only; `pc`=1 and `retire`=1 at cycle 3; FETCH at cycle 4.
- Store 16'h6_2A_0 at `pc`=4: `mem_write`=1 for exactly 1 cycle; `pc`=5; no `regfile_write`/`enbuf` pulse.
- Load 16'h7_2A_1: `mem_mux_sel`=1 for 3 cycles; `enbuf` 2 cycles; `regfile_write` 1 cycle in the last; total 4 cycles; `pc`+1.
- Branch matrix with target 8'h40: for each cond code 1000/0100/0101/0110/0111 × `flags` ∈ {00,01,10,11}, `pc`=8'h40 exactly when the rule holds, else `pc`+1. Code 0001 → not taken.
- `pc`=8'hFF with an ALU op → `pc`=8'h00 after WB. 16'h0000 fetched → `halted`=1 next cycle, `pc` frozen for 20 cycles, no strobes. `rst_n` low then high → `pc`=`RESET_PC`, `halted`=0.
- Stall and async abort:
  - `run`=0 for 5 cycles in FETCH: `pc` and `ir` unchanged, no `retire`.
  - Drop `run` during EXEC: the instruction completes, then the controller stalls.
  - Assert `rst_n`=0 mid-MEMB: all strobes 0 within the same cycle, state FETCH.
